// File: rtl/alvio_wr_queue.sv
// Write-side staging queue for the active-list violation RAM: coalesces per-lane
// violation reports and drains them one per cycle into the RAM write port.
module alvio_wr_queue #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned QINDEX  = 2,
  parameter int unsigned INDEX   = 4,
  parameter int unsigned WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic [NUM_SRC-1:0]         srcValid_i,
  input  logic [NUM_SRC*INDEX-1:0]   srcAlId_i,
  input  logic [NUM_SRC*WIDTH-1:0]   srcData_i,
  output logic                       ready_o,
  output logic                       we0_o,
  output logic [INDEX-1:0]           addr0wr_o,
  output logic [WIDTH-1:0]           data0wr_o,
  output logic [QINDEX:0]            count_o,
  output logic                       overflow_o
);

  localparam int unsigned CW = QINDEX + 1;

  logic [INDEX-1:0]  q_al     [QDEPTH];
  logic [WIDTH-1:0]  q_data   [QDEPTH];
  logic [INDEX-1:0]  q_al_n   [QDEPTH];
  logic [WIDTH-1:0]  q_data_n [QDEPTH];
  logic [QINDEX-1:0] head;
  logic [QINDEX-1:0] tail;
  logic [CW-1:0]     count;

  logic [INDEX-1:0]  lane_al   [NUM_SRC];
  logic [WIDTH-1:0]  lane_raw  [NUM_SRC];
  logic [WIDTH-1:0]  lane_data [NUM_SRC];
  logic [NUM_SRC-1:0] lane_live;

  logic [QINDEX-1:0] offs [QDEPTH];
  logic [QDEPTH-1:0] match_ok;

  logic              pop;
  logic [CW-1:0]     free_slots;
  logic [CW-1:0]     n_alloc;
  logic [QINDEX-1:0] slot;
  logic              drop;
  logic              hit;
  logic              bypass_used;
  logic              out_we;
  logic [INDEX-1:0]  out_addr;
  logic [WIDTH-1:0]  out_data;

  assign pop     = (count != '0);
  assign count_o = count;
  assign ready_o = (count <= CW'(QDEPTH - NUM_SRC));

  // Unpack the flattened lane buses
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      lane_al[i]  = srcAlId_i[i*INDEX +: INDEX];
      lane_raw[i] = srcData_i[i*WIDTH +: WIDTH];
    end
  end

  // Same-cycle coalesce: lowest matching lane survives and collects the OR of the rest
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      lane_live[i] = srcValid_i[i];
      lane_data[i] = lane_raw[i];
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
        if (srcValid_i[j] && (lane_al[j] == lane_al[i])) begin
          if (j < i)
            lane_live[i] = 1'b0;
          else if (j > i)
            lane_data[i] = lane_data[i] | lane_raw[j];
        end
      end
    end
  end

  // Occupied entries that may absorb a lane; the entry leaving this cycle cannot
  always_comb begin
    for (int unsigned k = 0; k < QDEPTH; k++) begin
      offs[k]     = QINDEX'(k) - head;
      match_ok[k] = ({1'b0, offs[k]} < count) && !(pop && (QINDEX'(k) == head));
    end
  end

  // Pop/bypass selection, queue merge and in-order allocation
  always_comb begin
    q_al_n      = q_al;
    q_data_n    = q_data;
    out_we      = 1'b0;
    out_addr    = addr0wr_o;
    out_data    = data0wr_o;
    n_alloc     = '0;
    slot        = '0;
    drop        = 1'b0;
    hit         = 1'b0;
    bypass_used = 1'b0;
    free_slots  = CW'(QDEPTH) - count + CW'(pop);

    if (pop) begin
      out_we   = 1'b1;
      out_addr = q_al[head];
      out_data = q_data[head];
    end

    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (lane_live[i]) begin
        hit = 1'b0;
        for (int unsigned k = 0; k < QDEPTH; k++) begin
          if (match_ok[k] && (q_al[k] == lane_al[i])) begin
            q_data_n[k] = q_data_n[k] | lane_data[i];
            hit         = 1'b1;
          end
        end
        if (!hit) begin
          if (!pop && !bypass_used) begin
            out_we      = 1'b1;
            out_addr    = lane_al[i];
            out_data    = lane_data[i];
            bypass_used = 1'b1;
          end else if (n_alloc < free_slots) begin
            slot           = tail + n_alloc[QINDEX-1:0];
            q_al_n[slot]   = lane_al[i];
            q_data_n[slot] = lane_data[i];
            n_alloc        = n_alloc + CW'(1);
          end else begin
            drop = 1'b1;
          end
        end
      end
    end
  end

  // Pointers, occupancy and the registered RAM write port
  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      we0_o      <= 1'b0;
      addr0wr_o  <= '0;
      data0wr_o  <= '0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      we0_o <= 1'b0;
    end else begin
      head      <= head + QINDEX'(pop);
      tail      <= tail + n_alloc[QINDEX-1:0];
      count     <= count - CW'(pop) + n_alloc;
      we0_o     <= out_we;
      addr0wr_o <= out_addr;
      data0wr_o <= out_data;
      if (drop)
        overflow_o <= 1'b1;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by head/count
  always_ff @(posedge clk) begin
    if (!reset && !flush_i) begin
      for (int unsigned k = 0; k < QDEPTH; k++) begin
        q_al[k]   <= q_al_n[k];
        q_data[k] <= q_data_n[k];
      end
    end
  end

endmodule

// File: tb/tb_alvio_wr_queue.sv
// Scoreboard bench for alvio_wr_queue: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares every asserted we0_o.
module tb_alvio_wr_queue;

  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned QDEPTH  = 4;
  localparam int unsigned QINDEX  = 2;
  localparam int unsigned INDEX   = 4;
  localparam int unsigned WIDTH   = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     flush_i;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC*INDEX-1:0] src_al;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic                     ready_o;
  logic                     we0_o;
  logic [INDEX-1:0]         addr0wr_o;
  logic [WIDTH-1:0]         data0wr_o;
  logic [QINDEX:0]          count_o;
  logic                     overflow_o;

  typedef struct packed {
    logic [INDEX-1:0] a;
    logic [WIDTH-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_w;
  int  total = 0;
  int  bad   = 0;

  alvio_wr_queue #(
    .NUM_SRC(NUM_SRC), .QDEPTH(QDEPTH), .QINDEX(QINDEX), .INDEX(INDEX), .WIDTH(WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .srcValid_i(src_valid), .srcAlId_i(src_al), .srcData_i(src_data),
    .ready_o(ready_o), .we0_o(we0_o), .addr0wr_o(addr0wr_o), .data0wr_o(data0wr_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [INDEX-1:0] a, input logic [WIDTH-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // One cycle of lane stimulus, released right after the capturing edge
  task automatic cyc(input logic [1:0] v, input logic [3:0] a0, input logic [7:0] d0,
                     input logic [3:0] a1, input logic [7:0] d1, input logic fl);
    src_valid = v;
    src_al    = {a1, a0};
    src_data  = {d1, d0};
    flush_i   = fl;
    @(posedge clk);
    #1;
    src_valid = '0;
    flush_i   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && (count_o != '0 || exp_q.size() != 0); i++)
      idle(1);
    idle(1);
    chk(name, exp_q.size(), 0);
  endtask

  // Every RAM write must be the next expected one
  always @(negedge clk) begin
    if (we0_o === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h want no write", addr0wr_o, data0wr_o);
      end else begin
        exp_w = exp_q.pop_front();
        if ({addr0wr_o, data0wr_o} !== exp_w) begin
          bad++;
          $display("FAIL write_order: got addr=%0h data=%0h want addr=%0h data=%0h",
                   addr0wr_o, data0wr_o, exp_w.a, exp_w.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    flush_i   = 1'b0;
    src_valid = '0;
    src_al    = '0;
    src_data  = '0;
    idle(2);
    reset = 1'b0;
    chk("rst_we", we0_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_addr", addr0wr_o, 0);
    chk("rst_data", data0wr_o, 0);

    // Bypass
    push(4'd5, 8'h01);
    cyc(2'b01, 4'd5, 8'h01, 4'd0, 8'h00, 1'b0);
    chk("byp_count", count_o, 0);
    idle(1);
    chk("byp_we_off", we0_o, 0);

    // Same-cycle coalesce
    push(4'd3, 8'h05);
    cyc(2'b11, 4'd3, 8'h01, 4'd3, 8'h04, 1'b0);
    chk("sc_count", count_o, 0);
    idle(1);
    chk("sc_we_off", we0_o, 0);

    // Lane hits only the entry leaving this cycle: allocates a fresh entry
    push(4'd2, 8'h01);
    push(4'd7, 8'h02);
    push(4'd7, 8'h08);
    cyc(2'b11, 4'd2, 8'h01, 4'd7, 8'h02, 1'b0);
    chk("hx_count1", count_o, 1);
    cyc(2'b01, 4'd7, 8'h08, 4'd0, 8'h00, 1'b0);
    chk("hx_count2", count_o, 1);
    drain("hx_drain");

    // Queue coalesce into a non-head entry
    push(4'd1, 8'h01);
    push(4'd4, 8'h02);
    push(4'd5, 8'h04);
    push(4'd6, 8'h18);
    cyc(2'b11, 4'd1, 8'h01, 4'd4, 8'h02, 1'b0);
    cyc(2'b11, 4'd5, 8'h04, 4'd6, 8'h08, 1'b0);
    chk("qc_count1", count_o, 2);
    cyc(2'b01, 4'd6, 8'h10, 4'd0, 8'h00, 1'b0);
    chk("qc_count2", count_o, 1);
    drain("qc_drain");

    // Fill, back-pressure, overflow and drain across pointer wrap
    push(4'd1, 8'h11); push(4'd2, 8'h12);
    push(4'd3, 8'h13); push(4'd4, 8'h14);
    push(4'd5, 8'h15); push(4'd6, 8'h16);
    push(4'd8, 8'h18); push(4'd9, 8'h19);
    push(4'd10, 8'h1a);
    chk("fill_ready0", ready_o, 1);
    cyc(2'b11, 4'd1, 8'h11, 4'd2, 8'h12, 1'b0);
    chk("fill_count1", count_o, 1);
    cyc(2'b11, 4'd3, 8'h13, 4'd4, 8'h14, 1'b0);
    chk("fill_count2", count_o, 2);
    chk("fill_ready2", ready_o, 1);
    cyc(2'b11, 4'd5, 8'h15, 4'd6, 8'h16, 1'b0);
    chk("fill_count3", count_o, 3);
    chk("fill_ready3", ready_o, 0);
    chk("fill_ovf3", overflow_o, 0);
    cyc(2'b11, 4'd8, 8'h18, 4'd9, 8'h19, 1'b0);
    chk("fill_count4", count_o, 4);
    cyc(2'b11, 4'd10, 8'h1a, 4'd11, 8'h1b, 1'b0);
    chk("fill_count5", count_o, 4);
    chk("fill_ovf", overflow_o, 1);
    drain("fill_drain");
    chk("fill_ready_end", ready_o, 1);

    // Flush with three entries queued; alId 9 must never be written
    push(4'd1, 8'h21); push(4'd2, 8'h22); push(4'd3, 8'h23);
    cyc(2'b11, 4'd1, 8'h21, 4'd2, 8'h22, 1'b0);
    cyc(2'b11, 4'd3, 8'h23, 4'd4, 8'h24, 1'b0);
    cyc(2'b11, 4'd5, 8'h25, 4'd6, 8'h26, 1'b0);
    chk("fl_count_pre", count_o, 3);
    cyc(2'b01, 4'd9, 8'h01, 4'd0, 8'h00, 1'b1);
    chk("fl_we", we0_o, 0);
    chk("fl_count", count_o, 0);
    chk("fl_ready", ready_o, 1);
    chk("fl_ovf_sticky", overflow_o, 1);
    idle(3);
    chk("fl_no_more", exp_q.size(), 0);

    // Reset mid-drain
    push(4'd1, 8'h31); push(4'd2, 8'h32); push(4'd3, 8'h33);
    cyc(2'b11, 4'd1, 8'h31, 4'd2, 8'h32, 1'b0);
    cyc(2'b11, 4'd3, 8'h33, 4'd4, 8'h34, 1'b0);
    cyc(2'b11, 4'd5, 8'h35, 4'd6, 8'h36, 1'b0);
    chk("rs_count_pre", count_o, 3);
    reset     = 1'b1;
    src_valid = 2'b01;
    src_al    = {4'd0, 4'd9};
    src_data  = {8'h00, 8'h01};
    idle(1);
    reset     = 1'b0;
    src_valid = '0;
    chk("rs_we", we0_o, 0);
    chk("rs_count", count_o, 0);
    chk("rs_ovf", overflow_o, 0);
    chk("rs_addr", addr0wr_o, 0);
    chk("rs_data", data0wr_o, 0);
    chk("rs_ready", ready_o, 1);
    idle(3);
    chk("rs_no_more", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
